// File: rtl/cp0_vec_irq_pkg.sv
// Shared CP0 definitions: operation codes, register addresses and STATUS/CAUSE bit positions.
package cp0_vec_irq_pkg;

    localparam logic [1:0] EXE_CP_NONE  = 2'b00;
    localparam logic [1:0] EXE_CP_STORE = 2'b01;
    localparam logic [1:0] EXE_CP0_ERET = 2'b10;

    localparam logic [4:0] CP0_COUNT   = 5'd9;
    localparam logic [4:0] CP0_COMPARE = 5'd11;
    localparam logic [4:0] CP0_STATUS  = 5'd12;
    localparam logic [4:0] CP0_CAUSE   = 5'd13;
    localparam logic [4:0] CP0_EPCR    = 5'd14;
    localparam logic [4:0] CP0_EHBR    = 5'd15;

    localparam int STATUS_IE      = 0;
    localparam int STATUS_EXL     = 1;
    localparam int STATUS_MASK_LO = 8;
    localparam int CAUSE_CODE_LO  = 2;
    localparam int CAUSE_PEND_LO  = 8;

    function automatic logic [31:0] vec_offset(input logic [2:0] id, input int shift);
        return 32'(id) << shift;
    endfunction

endpackage

// File: rtl/cp0_vec_irq_irq_sync_edge.sv
// Per-line synchroniser followed by a rising-edge detector on the synchronised value.
module irq_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_line,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_line};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_rise = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/cp0_vec_irq.sv
// Vectored-interrupt CP0: synchronised edge-latched IRQs, masked lowest-index priority, ERET/MTC0.
// Optional compare timer channel enabled by defining CP0_TIMER_EN.
module cp0_vec_irq
    import cp0_vec_irq_pkg::*;
#(
    parameter int N_IRQ       = 4,
    parameter int VEC_SHIFT   = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       oper,
    input  logic [4:0]       addr_r,
    output logic [31:0]      data_r,
    input  logic [4:0]       addr_w,
    input  logic [31:0]      data_w,
    input  logic             ir_en,
    input  logic [N_IRQ-1:0] ir_in,
    input  logic [31:0]      ret_addr,
    output logic             jump_en,
    output logic [31:0]      jump_addr,
    output logic             ir,
    output logic [2:0]       ir_id
);

`ifdef CP0_TIMER_EN
    localparam int NP = N_IRQ + 1;
`else
    localparam int NP = N_IRQ;
`endif

    logic [N_IRQ-1:0] w_rise;
    logic [NP-1:0]    r_pend, r_mask, w_pm, w_win, w_clr, w_set, w_tclr;
    logic             r_ie, r_exl, r_jump_en, r_ir;
    logic [2:0]       r_code, w_id;
    logic [31:0]      r_epcr, r_ehbr, r_jump_addr;
    logic             w_eret, w_store, w_take;

    for (genvar g = 0; g < N_IRQ; g++) begin : g_sync
        irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_line (ir_in[g]),
            .o_rise (w_rise[g])
        );
    end

    // Lowest set index wins: scan downwards so the last hit is the smallest.
    always_comb begin
        w_pm  = r_pend & r_mask;
        w_id  = '0;
        w_win = '0;
        for (int i = NP - 1; i >= 0; i--) begin
            if (w_pm[i]) begin
                w_id     = 3'(i);
                w_win    = '0;
                w_win[i] = 1'b1;
            end
        end
        w_eret  = (oper == EXE_CP0_ERET);
        w_store = (oper == EXE_CP_STORE);
        w_take  = ir_en & r_ie & ~r_exl & (|w_pm) & ~w_eret & ~w_store;
        w_clr   = w_take ? w_win : '0;
    end

`ifdef CP0_TIMER_EN
    logic [31:0] r_count, r_compare;
    logic        w_cmp_wr;

    assign w_cmp_wr = w_store && (addr_w == CP0_COMPARE);
    assign w_set    = {(r_count == r_compare) && (r_compare != '0), w_rise};
    assign w_tclr   = {w_cmp_wr, {N_IRQ{1'b0}}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count   <= '0;
            r_compare <= '0;
        end else begin
            if (w_store && (addr_w == CP0_COUNT)) r_count <= data_w;
            else                                   r_count <= r_count + 32'd1;
            if (w_cmp_wr) r_compare <= data_w;
        end
    end
`else
    assign w_set  = w_rise;
    assign w_tclr = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend      <= '0;
            r_mask      <= '1;
            r_ie        <= 1'b1;
            r_exl       <= 1'b0;
            r_code      <= '0;
            r_epcr      <= '0;
            r_ehbr      <= '0;
            r_jump_en   <= 1'b0;
            r_jump_addr <= '0;
            r_ir        <= 1'b0;
        end else begin
            // A fresh edge on the line being taken re-arms it; a COMPARE write beats a timer match.
            r_pend      <= ((r_pend & ~w_clr) | w_set) & ~w_tclr;
            r_jump_en   <= 1'b0;
            r_jump_addr <= '0;
            r_ir        <= 1'b0;
            if (w_eret) begin
                r_jump_en   <= 1'b1;
                r_jump_addr <= r_epcr;
                r_exl       <= 1'b0;
            end else if (w_store) begin
                case (addr_w)
                    CP0_STATUS: begin
                        r_ie   <= data_w[STATUS_IE];
                        r_exl  <= data_w[STATUS_EXL];
                        r_mask <= data_w[STATUS_MASK_LO +: NP];
                    end
                    CP0_EPCR: r_epcr <= data_w;
                    CP0_EHBR: r_ehbr <= data_w;
                    default: ;
                endcase
            end else if (w_take) begin
                r_epcr      <= ret_addr;
                r_exl       <= 1'b1;
                r_code      <= w_id;
                r_ir        <= 1'b1;
                r_jump_en   <= 1'b1;
                r_jump_addr <= r_ehbr + vec_offset(w_id, VEC_SHIFT);
            end
        end
    end

    always_comb begin
        data_r = '0;
        case (addr_r)
            CP0_STATUS: begin
                data_r[STATUS_IE]            = r_ie;
                data_r[STATUS_EXL]           = r_exl;
                data_r[STATUS_MASK_LO +: NP] = r_mask;
            end
            CP0_CAUSE: begin
                data_r[CAUSE_PEND_LO +: NP] = r_pend;
                data_r[CAUSE_CODE_LO +: 3]  = r_code;
            end
            CP0_EPCR: data_r = r_epcr;
            CP0_EHBR: data_r = r_ehbr;
`ifdef CP0_TIMER_EN
            CP0_COUNT:   data_r = r_count;
            CP0_COMPARE: data_r = r_compare;
`endif
            default: ;
        endcase
    end

    assign jump_en   = r_jump_en;
    assign jump_addr = r_jump_addr;
    assign ir        = r_ir;
    assign ir_id     = r_code;

endmodule

// File: tb/tb_cp0_vec_irq.sv
// Directed bench for cp0_vec_irq (N_IRQ=4, VEC_SHIFT=4, SYNC_STAGES=2); timer steps under CP0_TIMER_EN.
module tb_cp0_vec_irq;
    import cp0_vec_irq_pkg::*;

`ifdef CP0_TIMER_EN
    localparam logic [31:0] ST_MASK = 32'h0000_1F00;
`else
    localparam logic [31:0] ST_MASK = 32'h0000_0F00;
`endif

    logic        clk, rst_n;
    logic [1:0]  oper;
    logic [4:0]  addr_r, addr_w;
    logic [31:0] data_r, data_w, ret_addr, jump_addr;
    logic        ir_en, jump_en, ir;
    logic [3:0]  ir_in;
    logic [2:0]  ir_id;
    int          n_cmp, n_fail, n_ir;

    cp0_vec_irq #(.N_IRQ(4), .VEC_SHIFT(4), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .oper      (oper),
        .addr_r    (addr_r),
        .data_r    (data_r),
        .addr_w    (addr_w),
        .data_w    (data_w),
        .ir_en     (ir_en),
        .ir_in     (ir_in),
        .ret_addr  (ret_addr),
        .jump_en   (jump_en),
        .jump_addr (jump_addr),
        .ir        (ir),
        .ir_id     (ir_id)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic en, input logic [31:0] a,
                           input logic irv, input logic [2:0] id);
        chk({tag, "_jump_en"}, {31'b0, jump_en}, {31'b0, en});
        chk({tag, "_jump_addr"}, jump_addr, a);
        chk({tag, "_ir"}, {31'b0, ir}, {31'b0, irv});
        chk({tag, "_ir_id"}, {29'b0, ir_id}, {29'b0, id});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string tag);
        addr_r = a;
        #1;
        chk(tag, data_r, exp);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        oper   = EXE_CP_STORE;
        addr_w = a;
        data_w = d;
        step();
        oper   = EXE_CP_NONE;
    endtask

    task automatic eret();
        oper = EXE_CP0_ERET;
        step();
        oper = EXE_CP_NONE;
    endtask

    initial begin
        n_cmp = 0; n_fail = 0; n_ir = 0;
        rst_n = 1'b0; oper = EXE_CP_NONE; addr_r = '0; addr_w = '0; data_w = '0;
        ir_en = 1'b0; ir_in = '0; ret_addr = '0;
        #15;
        chk_out("rst", 1'b0, 32'h0, 1'b0, 3'd0);
        rd(CP0_STATUS, ST_MASK | 32'h1, "rst_status");
        rd(CP0_CAUSE, 32'h0, "rst_cause");
        rd(CP0_EPCR, 32'h0, "rst_epcr");
        rd(CP0_EHBR, 32'h0, "rst_ehbr");
        rst_n = 1'b1;
        step();

        // Single line, full latency and vector address
        wr(CP0_EHBR, 32'h0000_1000);
        ret_addr = 32'h100; ir_en = 1'b1; ir_in = 4'b0100;
        steps(2);
        chk("t1_no_early_jump", {31'b0, jump_en}, 32'h0);
        step();
        rd(CP0_CAUSE, 32'h400, "t1_pend_set");
        chk("t1_no_take_yet", {31'b0, ir}, 32'h0);
        step();
        chk_out("t1_take", 1'b1, 32'h0000_1020, 1'b1, 3'd2);
        rd(CP0_EPCR, 32'h100, "t1_epcr");
        rd(CP0_CAUSE, 32'h008, "t1_cause");
        rd(CP0_STATUS, ST_MASK | 32'h3, "t1_status_exl");
        step();
        chk_out("t1_pulse_end", 1'b0, 32'h0, 1'b0, 3'd2);
        ir_in = '0;
        wr(CP0_CAUSE, 32'hFFFF_FFFF);
        rd(CP0_CAUSE, 32'h008, "cause_ro");
        wr(5'd20, 32'hDEAD_BEEF);
        rd(5'd20, 32'h0, "unmapped");

        // Two lines together, lowest id first, second taken after ERET
        eret();
        chk_out("t2_eret0", 1'b1, 32'h100, 1'b0, 3'd2);
        rd(CP0_STATUS, ST_MASK | 32'h1, "t2_exl_clr");
        ret_addr = 32'h200; ir_in = 4'b1010;
        steps(3);
        rd(CP0_CAUSE, 32'hA08, "t2_pend_both");
        step();
        chk_out("t2_take1", 1'b1, 32'h0000_1010, 1'b1, 3'd1);
        rd(CP0_CAUSE, 32'h804, "t2_cause");
        steps(2);
        chk("t2_exl_blocks", {31'b0, ir}, 32'h0);
        ir_in = '0; ret_addr = 32'h300;
        eret();
        chk_out("t2_eret", 1'b1, 32'h200, 1'b0, 3'd1);
        step();
        chk_out("t2_take3", 1'b1, 32'h0000_1030, 1'b1, 3'd3);
        rd(CP0_EPCR, 32'h300, "t2_epcr");
        eret();
        chk_out("t2_eret2", 1'b1, 32'h300, 1'b0, 3'd3);

        // Masked line stays pending until unmasked
        wr(CP0_STATUS, (ST_MASK & ~32'h100) | 32'h1);
        ir_in = 4'b0001;
        step();
        ir_in = '0;
        steps(4);
        chk("t3_masked_no_take", {31'b0, ir}, 32'h0);
        rd(CP0_CAUSE, 32'h10C, "t3_pend0");
        ret_addr = 32'h400;
        wr(CP0_STATUS, ST_MASK | 32'h1);
        chk("t3_store_cycle", {31'b0, ir}, 32'h0);
        step();
        chk_out("t3_take0", 1'b1, 32'h0000_1000, 1'b1, 3'd0);
        eret();
        chk_out("t3_eret", 1'b1, 32'h400, 1'b0, 3'd0);

        // ERET and STORE outrank a pending take for one cycle
        ret_addr = 32'h500; ir_in = 4'b0010;
        steps(3);
        eret();
        chk_out("t4_eret_wins", 1'b1, 32'h400, 1'b0, 3'd0);
        step();
        chk_out("t4_take1", 1'b1, 32'h0000_1010, 1'b1, 3'd1);
        ir_in = '0; ret_addr = 32'h600;
        eret();
        chk_out("t4_eret2", 1'b1, 32'h500, 1'b0, 3'd1);
        ir_in = 4'b0100;
        steps(3);
        wr(CP0_EHBR, 32'h0000_2000);
        chk_out("t4_store_wins", 1'b0, 32'h0, 1'b0, 3'd1);
        step();
        chk_out("t4_take2", 1'b1, 32'h0000_2020, 1'b1, 3'd2);
        ir_in = '0;
        eret();
        chk_out("t4_eret3", 1'b1, 32'h600, 1'b0, 3'd2);

`ifdef CP0_TIMER_EN
        wr(CP0_COMPARE, 32'd20);
        wr(CP0_COUNT, 32'd0);
        rd(CP0_COUNT, 32'd0, "tm_count_load");
        steps(21);
        chk("tm_no_take_yet", {31'b0, ir}, 32'h0);
        rd(CP0_CAUSE, 32'h1008, "tm_pend");
        step();
        chk_out("tm_take", 1'b1, 32'h0000_2040, 1'b1, 3'd4);
        rd(CP0_STATUS, ST_MASK | 32'h3, "tm_exl");
        wr(CP0_COUNT, 32'd0);
        steps(21);
        rd(CP0_CAUSE, 32'h1010, "tm_pend2");
        wr(CP0_COMPARE, 32'd50);
        rd(CP0_CAUSE, 32'h0010, "tm_cmp_clr");
        rd(CP0_COMPARE, 32'd50, "tm_compare_rd");
        wr(CP0_COMPARE, 32'd0);
        eret();
        chk_out("tm_eret", 1'b1, 32'h600, 1'b0, 3'd4);
`else
        wr(CP0_COUNT, 32'd5);
        wr(CP0_COMPARE, 32'd5);
        rd(CP0_COUNT, 32'h0, "no_timer_count");
        rd(CP0_COMPARE, 32'h0, "no_timer_compare");
`endif

        // Held line does not retrigger; async reset kills EXL and the pulse
        ret_addr = 32'h700; ir_in = 4'b0001;
        steps(4);
        chk_out("t5_take0", 1'b1, 32'h0000_2000, 1'b1, 3'd0);
        eret();
        chk_out("t5_eret", 1'b1, 32'h700, 1'b0, 3'd0);
        for (int i = 0; i < 6; i++) begin
            step();
            n_ir += int'(ir);
        end
        chk("t5_no_retrigger", 32'(n_ir), 32'h0);
        rd(CP0_CAUSE, 32'h0, "t5_no_pend");
        ir_in = '0;
        steps(2);
        ir_in = 4'b0001;
        steps(4);
        chk("t5_retake", {31'b0, ir}, 32'h1);
        rd(CP0_STATUS, ST_MASK | 32'h3, "t5_exl_set");
        rst_n = 1'b0;
        #1;
        chk("t5_rst_jump_en", {31'b0, jump_en}, 32'h0);
        chk("t5_rst_ir", {31'b0, ir}, 32'h0);
        chk("t5_rst_jump_addr", jump_addr, 32'h0);
        rd(CP0_STATUS, ST_MASK | 32'h1, "t5_rst_status");
        rd(CP0_EHBR, 32'h0, "t5_rst_ehbr");
        ir_in = '0;
        rst_n = 1'b1;
        step();
        chk_out("t5_after_rst", 1'b0, 32'h0, 1'b0, 3'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
